// File: rtl/dmem_stream_loader.sv
// ---------------------------------------------------------------------------
// dmem_stream_loader
//   Takes a valid/ready word stream and writes it into core data memory via
//   the top-level tb-write port. The loader owns the memory address mux while
//   loading. After the last word it hands the mux back to the core and pulses
//   START to launch the matmul.
//
// Ports
//   clk              system clock, rising edge
//   RESET            asynchronous, active-high reset
//   load_go          1-cycle load request, sampled only while idle
//   load_len         number of words to load, latched on load_go
//   s_data/s_valid   stream word and its valid flag
//   s_ready          loader accepts a word this cycle (depends on state only)
//   current_addr     data-memory write address
//   mem_data         data-memory write data
//   write_from_tb    data-memory write strobe, WR_PULSE cycles per word
//   addr_mux_select  0 = core owns memory, 1 = loader owns memory
//   START            1-cycle core start pulse after the last word
//   busy             high whenever the loader is not idle
//   load_done        1-cycle pulse, coincident with START
//   len_err          1-cycle pulse after load_go with load_len 0 or > DMEM_SIZE
// ---------------------------------------------------------------------------
module dmem_stream_loader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DMEM_SIZE = 1000,
  parameter int WR_PULSE  = 2
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              load_go,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] current_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              write_from_tb,
  output logic [1:0]        addr_mux_select,
  output logic              START,
  output logic              busy,
  output logic              load_done,
  output logic              len_err
);

  localparam int CNT_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DMEM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_KICK
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              len_ok;
  logic              last_word;
  logic              pulse_last;
  logic              len_err_q;

  assign len_ok     = (load_len != '0) && ({1'b0, load_len} <= MAX_LEN);
  assign last_word  = (current_addr == (len_q - ADDR_W'(1)));
  assign pulse_last = (cnt_q == CNT_W'(WR_PULSE - 1));

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (load_go && len_ok) state_d = S_WAIT;
      S_WAIT:  if (s_valid)           state_d = S_SETUP;
      S_SETUP:                        state_d = S_WRITE;
      S_WRITE: if (pulse_last)        state_d = S_HOLD;
      S_HOLD:  state_d = last_word ? S_KICK : S_WAIT;
      S_KICK:                         state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Strobe, mux and pulses are decoded from the state register alone so that
  // an asynchronous reset drops them in the same cycle.
  always_comb begin
    s_ready         = 1'b0;
    write_from_tb   = 1'b0;
    addr_mux_select = 2'd0;
    START           = 1'b0;
    load_done       = 1'b0;
    busy            = (state_q != S_IDLE);
    unique case (state_q)
      S_WAIT: begin
        s_ready         = 1'b1;
        addr_mux_select = 2'd1;
      end
      S_SETUP, S_HOLD: addr_mux_select = 2'd1;
      S_WRITE: begin
        addr_mux_select = 2'd1;
        write_from_tb   = 1'b1;
      end
      S_KICK: begin
        START     = 1'b1;
        load_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign len_err = len_err_q;

  // Address and data persist across IDLE; only a legal load_go clears the address.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      len_q        <= '0;
      current_addr <= '0;
      mem_data     <= '0;
      cnt_q        <= '0;
      len_err_q    <= 1'b0;
    end else begin
      len_err_q <= (state_q == S_IDLE) && load_go && !len_ok;
      unique case (state_q)
        S_IDLE: if (load_go && len_ok) begin
          len_q        <= load_len;
          current_addr <= '0;
        end
        S_WAIT:  if (s_valid) mem_data <= s_data;
        S_SETUP: cnt_q <= '0;
        S_WRITE: if (!pulse_last) cnt_q <= cnt_q + CNT_W'(1);
        S_HOLD:  if (!last_word) current_addr <= current_addr + ADDR_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stream_loader.sv
`timescale 1ns/1ps
module tb_dmem_stream_loader;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        load_go = 1'b0;
  logic [15:0] load_len = '0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] current_addr;
  logic [15:0] mem_data;
  logic        write_from_tb;
  logic [1:0]  addr_mux_select;
  logic        START;
  logic        busy;
  logic        load_done;
  logic        len_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int wr_addr[$];
  int wr_data[$];
  int widths[$];
  int rise_cyc[$];
  int acc_cyc[$];
  int start_cnt, done_cnt, lenerr_cnt, pulse_bad, run;
  logic prev_wr = 1'b0;

  dmem_stream_loader #(
    .DATA_W(16), .ADDR_W(16), .DMEM_SIZE(1000), .WR_PULSE(2)
  ) dut (
    .clk(clk), .RESET(RESET), .load_go(load_go), .load_len(load_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .current_addr(current_addr), .mem_data(mem_data),
    .write_from_tb(write_from_tb), .addr_mux_select(addr_mux_select),
    .START(START), .busy(busy), .load_done(load_done), .len_err(len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive recorder of memory writes and pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (write_from_tb && !prev_wr) begin
      wr_addr.push_back(int'(current_addr));
      wr_data.push_back(int'(mem_data));
      rise_cyc.push_back(cyc);
      run = 1;
    end else if (write_from_tb) begin
      run = run + 1;
    end else if (prev_wr) begin
      widths.push_back(run);
    end
    prev_wr = write_from_tb;
    if (START === 1'b1) start_cnt++;
    if (load_done === 1'b1) done_cnt++;
    if (len_err === 1'b1) lenerr_cnt++;
    if (START !== load_done) pulse_bad++;
  end

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); widths.delete();
    rise_cyc.delete(); acc_cyc.delete();
    start_cnt = 0; done_cnt = 0; lenerr_cnt = 0; pulse_bad = 0;
  endtask

  task automatic start_load(input int len);
    @(posedge clk); #1;
    load_go = 1'b1; load_len = 16'(len);
    @(posedge clk); #1;
    load_go = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] d, input bit keep_valid);
    int n = 0;
    s_data = d; s_valid = 1'b1;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL push_word: s_ready=%b after %0d cycles, required 1", s_ready, n);
      s_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc_cyc.push_back(cyc);
      if (!keep_valid) s_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    #1;
    checks++;
    if ({write_from_tb, addr_mux_select, START, busy, load_done, len_err, s_ready} !== 8'b0 ||
        current_addr !== 16'd0 || mem_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: outs=%b addr=%0d data=%0d, required all 0",
               {write_from_tb, addr_mux_select, START, busy, load_done, len_err, s_ready},
               current_addr, mem_data);
    end
    @(negedge clk); RESET = 1'b0;
    clear_log();
    start_load(3);
    push_word(16'h00AA, 1'b0);
    while (!write_from_tb && n < 20) begin @(negedge clk); n++; end
    check_int("reset_reached_write", int'(write_from_tb), 1);
    #2 RESET = 1'b1;
    #1;
    checks++;
    if ({write_from_tb, addr_mux_select, START, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_midwrite: wr/mux/start/busy=%b, required 00000",
               {write_from_tb, addr_mux_select, START, busy});
    end
    @(negedge clk); RESET = 1'b0;
    repeat (20) @(negedge clk);
    check_int("reset_no_start", start_cnt, 0);
    check_int("reset_busy_after", int'(busy), 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] d [3];
    d[0] = 16'd5; d[1] = 16'd7; d[2] = 16'd9;
    clear_log();
    start_load(3);
    for (int i = 0; i < 3; i++) push_word(d[i], i < 2);
    s_valid = 1'b0;
    wait_idle(100);
    check_int("b2b_writes", wr_addr.size(), 3);
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      check_int($sformatf("b2b_addr%0d", i), wr_addr[i], i);
      check_int($sformatf("b2b_data%0d", i), wr_data[i], int'(d[i]));
      check_int($sformatf("b2b_width%0d", i), widths[i], 2);
      check_int($sformatf("b2b_setup%0d", i), rise_cyc[i] - acc_cyc[i], 1);
    end
    for (int i = 1; i < acc_cyc.size(); i++)
      check_int($sformatf("b2b_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], 5);
    check_int("b2b_start", start_cnt, 1);
    check_int("b2b_done", done_cnt, 1);
    check_int("b2b_pulse_align", pulse_bad, 0);
    check_int("b2b_mux", int'(addr_mux_select), 0);
    check_int("b2b_hold_addr", int'(current_addr), 2);
    check_int("b2b_hold_data", int'(mem_data), 9);
  endtask

  task automatic test_stall();
    logic [15:0] d [3];
    d[0] = 16'h0011; d[1] = 16'h0022; d[2] = 16'h0033;
    clear_log();
    start_load(3);
    for (int i = 0; i < 3; i++) begin
      push_word(d[i], 1'b0);
      repeat (9) @(posedge clk);
      #1;
    end
    wait_idle(100);
    check_int("stall_writes", wr_addr.size(), 3);
    check_int("stall_strobes", widths.size(), 3);
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      check_int($sformatf("stall_addr%0d", i), wr_addr[i], i);
      check_int($sformatf("stall_data%0d", i), wr_data[i], int'(d[i]));
    end
    check_int("stall_start", start_cnt, 1);
  endtask

  task automatic test_len_err();
    int lens [2];
    int busy_seen;
    lens[0] = 0; lens[1] = 1001;
    clear_log();
    for (int k = 0; k < 2; k++) begin
      busy_seen = 0;
      start_load(lens[k]);
      repeat (6) begin @(negedge clk); if (busy) busy_seen++; end
      check_int($sformatf("lenerr_count_len%0d", lens[k]), lenerr_cnt, k + 1);
      check_int($sformatf("lenerr_busy_len%0d", lens[k]), busy_seen, 0);
    end
    check_int("lenerr_writes", wr_addr.size(), 0);
    check_int("lenerr_start", start_cnt, 0);
  endtask

  task automatic test_full_size();
    int bad = 0;
    int maxa = 0;
    clear_log();
    start_load(1000);
    for (int i = 0; i < 1000; i++) push_word(16'(i), i < 999);
    s_valid = 1'b0;
    wait_idle(100);
    check_int("full_writes", wr_addr.size(), 1000);
    foreach (wr_addr[i]) begin
      if (wr_addr[i] != i || wr_data[i] != i) bad++;
      if (wr_addr[i] > maxa) maxa = wr_addr[i];
    end
    check_int("full_addr_data_pairs", bad, 0);
    check_int("full_max_addr", maxa, 999);
    if (wr_addr.size() > 0) begin
      check_int("full_last_addr", wr_addr[wr_addr.size()-1], 999);
      check_int("full_last_data", wr_data[wr_data.size()-1], 999);
    end
    check_int("full_start", start_cnt, 1);
  endtask

  task automatic test_busy_go();
    clear_log();
    start_load(2);
    push_word(16'h0101, 1'b0);
    start_load(5);
    push_word(16'h0202, 1'b0);
    wait_idle(100);
    s_valid = 1'b1; s_data = 16'hBEEF;
    repeat (20) @(negedge clk);
    check_int("busygo_ready", int'(s_ready), 0);
    s_valid = 1'b0;
    check_int("busygo_writes", wr_addr.size(), 2);
    check_int("busygo_start", start_cnt, 1);
    check_int("busygo_done", done_cnt, 1);
    check_int("busygo_last_addr", int'(current_addr), 1);
  endtask

  initial begin
    clear_log();
    test_reset();
    test_back_to_back();
    test_stall();
    test_len_err();
    test_full_size();
    test_busy_go();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
